// File: rtl/ca_rng_pkg.sv
// Shared encodings for the cellular-automaton / LFSR random number generator.
// Holds the generator mode encoding and the warm-up/run state enum.
package rng_pkg;

  typedef enum logic [1:0] {
    RULE30  = 2'd0,
    RULE90  = 2'd1,
    RULE150 = 2'd2,
    LFSR    = 2'd3
  } rule_e;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ca_rng_step.sv
// One combinational generator step: cyclic 1-D CA rules 30/90/150 or a Galois LFSR.
// Also flags an all-zero result so the caller can repair the lockup.
module ca_rng_step
  import rng_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003)
) (
  input  logic [WIDTH-1:0] s,
  input  logic [1:0]       rule_sel,
  output logic [WIDTH-1:0] next_s,
  output logic             zero
);

  logic [WIDTH-1:0] r30;
  logic [WIDTH-1:0] r90;
  logic [WIDTH-1:0] r150;
  logic [WIDTH-1:0] lfsr;

  // Each cell sees its ring neighbours: left is i-1, right is i+1, wrapping around.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      localparam int L = (gi + WIDTH - 1) % WIDTH;
      localparam int R = (gi + 1) % WIDTH;
      assign r30[gi]  = s[L] ^ (s[gi] | s[R]);
      assign r90[gi]  = s[L] ^ s[R];
      assign r150[gi] = s[L] ^ s[gi] ^ s[R];
    end
  endgenerate

  assign lfsr = (s >> 1) ^ (s[0] ? TAPS : '0);

  always_comb begin
    next_s = lfsr;
    case (rule_e'(rule_sel))
      RULE30:  next_s = r30;
      RULE90:  next_s = r90;
      RULE150: next_s = r150;
      LFSR:    next_s = lfsr;
    endcase
  end

  assign zero = (next_s == '0);

endmodule

// File: rtl/ca_rng.sv
// Free-running random number generator with warm-up, seed reload, lockup repair
// and a zero-bubble take interface (req/out_valid).
module ca_rng
  import rng_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(32'h5A39),
  parameter int unsigned      WARMUP = 16,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(32'h80200003)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [1:0]       rule_sel,
  input  logic             req,
  output logic             out_valid,
  output logic [WIDTH-1:0] rand_out,
  output logic             lockup_seen
);

  // Counter value on which the last warm-up step happens (WARMUP=0 leaves on the first edge).
  localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  logic [WIDTH-1:0] s_reg, s_next;
  state_e           state_reg, state_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] rand_reg, rand_next;
  logic             valid_reg, valid_next;
  logic             lock_reg, lock_next;

  logic [WIDTH-1:0] step_s;
  logic             step_zero;
  logic [WIDTH-1:0] stepped;

  ca_rng_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .s        (s_reg),
    .rule_sel (rule_sel),
    .next_s   (step_s),
    .zero     (step_zero)
  );

  // An all-zero state is a fixed point of every mode, so it is replaced by SEED.
  // The repaired value is what gets presented on rand_out on that edge.
  assign stepped = step_zero ? SEED : step_s;

  always_comb begin
    s_next     = s_reg;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rand_next  = rand_reg;
    valid_next = valid_reg;
    lock_next  = lock_reg;
    if (seed_load) begin
      s_next     = (seed_in == '0) ? SEED : seed_in;
      state_next = WARM;
      cnt_next   = 8'd0;
      valid_next = 1'b0;
    end else begin
      s_next = stepped;
      if (step_zero) begin
        lock_next = 1'b1;
      end
      case (state_reg)
        WARM: begin
          if (cnt_reg == WARM_LAST) begin
            state_next = RUN;
            rand_next  = stepped;
            valid_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
        RUN: begin
          if (req && valid_reg) begin
            rand_next = stepped;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg     <= SEED;
      state_reg <= WARM;
      cnt_reg   <= 8'd0;
      rand_reg  <= '0;
      valid_reg <= 1'b0;
      lock_reg  <= 1'b0;
    end else begin
      s_reg     <= s_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rand_reg  <= rand_next;
      valid_reg <= valid_next;
      lock_reg  <= lock_next;
    end
  end

  assign out_valid   = valid_reg;
  assign rand_out    = rand_reg;
  assign lockup_seen = lock_reg;

endmodule

// File: tb/tb_ca_rng.sv
// Self-checking bench for ca_rng: an 8-bit, no-warm-up instance and a default 32-bit
// instance, both compared every cycle against a bit-loop reference model.
module tb_ca_rng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_sl, a_req, a_valid, a_lock;
  logic [7:0] a_seed, a_out;
  logic [1:0] a_rule;
  logic        b_sl, b_req, b_valid, b_lock;
  logic [31:0] b_seed, b_out;
  logic [1:0]  b_rule;

  ca_rng #(
    .WIDTH  (8),
    .SEED   (8'hA5),
    .WARMUP (0),
    .TAPS   (8'hB8)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .seed_load   (a_sl),
    .seed_in     (a_seed),
    .rule_sel    (a_rule),
    .req         (a_req),
    .out_valid   (a_valid),
    .rand_out    (a_out),
    .lockup_seen (a_lock)
  );

  ca_rng dut_b (
    .clk         (clk),
    .rst         (rst),
    .seed_load   (b_sl),
    .seed_in     (b_seed),
    .rule_sel    (b_rule),
    .req         (b_req),
    .out_valid   (b_valid),
    .rand_out    (b_out),
    .lockup_seen (b_lock)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-instance model configuration: index 0 = dut_a, 1 = dut_b.
  int              p_w[2]    = '{8, 32};
  longint unsigned p_seed[2] = '{64'hA5, 64'h5A39};
  int              p_warm[2] = '{0, 16};
  longint unsigned p_taps[2] = '{64'hB8, 64'h80200003};

  longint unsigned m_s[2], m_out[2];
  int              m_left[2];
  bit              m_run[2], m_valid[2], m_lock[2];

  function automatic longint unsigned wmask(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint unsigned model_step(input longint unsigned s, input int w,
                                                 input int rule, input longint unsigned taps);
    longint unsigned n;
    n = 64'd0;
    if (rule == 3) begin
      n = (s >> 1) ^ (s[0] ? taps : 64'd0);
    end else begin
      for (int i = 0; i < w; i++) begin
        bit l, c, r, b;
        l = s[(i + w - 1) % w];
        c = s[i];
        r = s[(i + 1) % w];
        case (rule)
          0:       b = l ^ (c | r);
          1:       b = l ^ r;
          default: b = l ^ c ^ r;
        endcase
        n[i] = b;
      end
    end
    return n & wmask(w);
  endfunction

  task automatic model_edge(input int k, input bit r, input bit sl, input longint unsigned sd,
                            input int rule, input bit rq);
    longint unsigned n;
    if (r) begin
      m_s[k] = p_seed[k]; m_run[k] = 0; m_left[k] = p_warm[k];
      m_out[k] = 0; m_valid[k] = 0; m_lock[k] = 0;
    end else if (sl) begin
      m_s[k] = ((sd & wmask(p_w[k])) == 0) ? p_seed[k] : (sd & wmask(p_w[k]));
      m_run[k] = 0; m_left[k] = p_warm[k]; m_valid[k] = 0;
    end else begin
      n = model_step(m_s[k], p_w[k], rule, p_taps[k]);
      if (n == 0) begin
        n = p_seed[k];
        m_lock[k] = 1;
      end
      m_s[k] = n;
      if (!m_run[k]) begin
        if (m_left[k] <= 1) begin
          m_run[k] = 1; m_out[k] = n; m_valid[k] = 1;
        end else begin
          m_left[k]--;
        end
      end else if (rq) begin
        m_out[k] = n;
      end
    end
  endtask

  task automatic cycle();
    model_edge(0, rst, a_sl, 64'(a_seed), int'(a_rule), a_req);
    model_edge(1, rst, b_sl, 64'(b_seed), int'(b_rule), b_req);
    @(posedge clk);
    #1;
    check("a_valid", 64'(a_valid), 64'(m_valid[0]));
    check("a_out",   64'(a_out),   m_out[0]);
    check("a_lock",  64'(a_lock),  64'(m_lock[0]));
    check("b_valid", 64'(b_valid), 64'(m_valid[1]));
    check("b_out",   64'(b_out),   m_out[1]);
    check("b_lock",  64'(b_lock),  64'(m_lock[1]));
  endtask

  // Cycles until dut_b presents a number, bounded.
  task automatic wait_b_valid(output int edges);
    edges = 0;
    while (!b_valid && edges < 40) begin
      cycle();
      edges++;
    end
  endtask

  longint unsigned ref16, hold;
  logic [7:0]      exp31[3];
  longint unsigned got_q[$];
  int              edges, dups;

  initial begin
    exp31[0] = 8'h83; exp31[1] = 8'h82; exp31[2] = 8'h83;
    rst = 1'b1;
    a_sl = 0; a_req = 0; a_seed = 0; a_rule = 0;
    b_sl = 0; b_req = 0; b_seed = 0; b_rule = 0;
    cycle();
    cycle();
    check("rst_b_out", 64'(b_out), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_a_lock", 64'(a_lock), 64'd0);

    rst = 1'b0;
    wait_b_valid(edges);
    check("warmup_edges", 64'(edges), 64'd16);
    ref16 = m_out[1];

    for (int r = 0; r < 3; r++) begin
      a_sl = 1; a_seed = 8'h01; a_rule = 2'(r);
      cycle();
      check("seed_load_a_valid", 64'(a_valid), 64'd0);
      a_sl = 0;
      cycle();
      check($sformatf("rule%0d_first", r), 64'(a_out), 64'(exp31[r]));
    end

    b_req = 1;
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("take_valid", 64'(b_valid), 64'd1);
      got_q.push_back(64'(b_out));
    end
    dups = 0;
    for (int i = 0; i < 10; i++)
      for (int j = i + 1; j < 10; j++)
        if (got_q[i] == got_q[j]) dups++;
    check("take_distinct_dups", 64'(dups), 64'd0);
    b_req = 0;
    hold = m_out[1];
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_out", 64'(b_out), hold);
    end

    a_rule = 1; a_sl = 1; a_seed = 8'hFF;
    cycle();
    a_sl = 0;
    cycle();
    check("lockup_flag", 64'(a_lock), 64'd1);
    a_rule = 0; a_sl = 1; a_seed = 8'h03;
    cycle();
    a_sl = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("lockup_sticky", 64'(a_lock), 64'd1);

    b_req = 1; b_sl = 1; b_seed = 0;
    cycle();
    check("sl_req_valid", 64'(b_valid), 64'd0);
    b_sl = 0; b_req = 0;
    wait_b_valid(edges);
    check("seed0_warm_edges", 64'(edges), 64'd16);
    check("seed0_same_as_seed", 64'(b_out), ref16);

    for (int i = 0; i < 800; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      a_sl   = ($urandom_range(0, 29) == 0);
      a_seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      a_rule = 2'($urandom);
      a_req  = 1'($urandom);
      b_sl   = ($urandom_range(0, 59) == 0);
      b_seed = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      b_rule = 2'($urandom);
      b_req  = 1'($urandom);
      cycle();
    end

    rst = 0; a_sl = 0; b_sl = 0; b_rule = 0; b_req = 1;
    wait_b_valid(edges);
    check("pre_rst_in_run", 64'(b_valid), 64'd1);
    rst = 1;
    cycle();
    check("mid_rst_out", 64'(b_out), 64'd0);
    check("mid_rst_valid", 64'(b_valid), 64'd0);
    check("mid_rst_lock", 64'(a_lock), 64'd0);
    rst = 0; b_req = 0;
    wait_b_valid(edges);
    check("rerun_warm_edges", 64'(edges), 64'd16);
    check("rerun_step16", 64'(b_out), ref16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
